// File: rtl/pwm_led_pkg.sv
`default_nettype none
// =============================================================================
// Module : pwm_led_pkg -- shared key indices, step commands and select width
// Rev    : 1.0  initial release
// =============================================================================
package pwm_led_pkg;

    localparam int KEY_UP = 0;
    localparam int KEY_DN = 1;

    typedef enum logic [1:0] {HOLD, INC, DEC, TOGGLE} step_cmd_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_led_chan.sv
`default_nettype none
// =============================================================================
// Module : pwm_led_chan -- one dimmer channel: shadow/active duty, compare, LED
//          Breathe ramp present only when PWM_LED_BREATHE_EN is defined.
// Rev    : 1.0  initial release
// =============================================================================
module pwm_led_chan
    import pwm_led_pkg::*;
#(
    parameter int PWM_W     = 10,
    parameter int DUTY_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_tick,
    input  step_cmd_t        cmd,
    input  logic             period_end,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led,
    output logic [PWM_W-1:0] duty,
    output logic             breathe
);

    localparam logic [PWM_W-1:0] c_duty_max  = '1;
    localparam logic [PWM_W-1:0] c_duty_init = PWM_W'(DUTY_INIT);

    logic [PWM_W-1:0] r_shd;
    logic [PWM_W-1:0] r_act;
    logic             r_led;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = (r_shd == c_duty_max);
    assign w_at_min = (r_shd == '0);

    // Active duty only follows the shadow at the period wrap, so a period never mixes two duties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act <= c_duty_init;
            r_led <= 1'b0;
        end else begin
            if (period_end)
                r_act <= r_shd;
            r_led <= (pwm_cnt < r_act);
        end
    end

`ifdef PWM_LED_BREATHE_EN
    logic r_breathe;
    logic r_dir_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shd     <= c_duty_init;
            r_breathe <= 1'b0;
            r_dir_dn  <= 1'b0;
        end else if (step_tick) begin
            if (cmd == TOGGLE) begin
                r_breathe <= ~r_breathe;
                r_dir_dn  <= 1'b0;
            end else if (r_breathe) begin
                // Endpoints hold for one tick while the direction flips.
                if (r_dir_dn) begin
                    if (w_at_min) r_dir_dn <= 1'b0;
                    else          r_shd    <= r_shd - 1'b1;
                end else begin
                    if (w_at_max) r_dir_dn <= 1'b1;
                    else          r_shd    <= r_shd + 1'b1;
                end
            end else if (cmd == INC && !w_at_max) begin
                r_shd <= r_shd + 1'b1;
            end else if (cmd == DEC && !w_at_min) begin
                r_shd <= r_shd - 1'b1;
            end
        end
    end

    assign breathe = r_breathe;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shd <= c_duty_init;
        end else if (step_tick) begin
            if (cmd == INC && !w_at_max)
                r_shd <= r_shd + 1'b1;
            else if (cmd == DEC && !w_at_min)
                r_shd <= r_shd - 1'b1;
        end
    end

    assign breathe = 1'b0;
`endif

    assign led  = r_led;
    assign duty = r_shd;

endmodule
`default_nettype wire

// File: rtl/pwm_led_multi.sv
`default_nettype none
// =============================================================================
// Module : pwm_led_multi -- key-driven multi-channel PWM LED dimmer (top)
//          Optional breathe mode: define PWM_LED_BREATHE_EN.
// Rev    : 1.0  initial release
// =============================================================================
module pwm_led_multi
    import pwm_led_pkg::*;
#(
    parameter  int CHANNELS  = 4,
    parameter  int PWM_W     = 10,
    parameter  int PRESC_W   = 4,
    parameter  int STEP_W    = 16,
    parameter  int DUTY_INIT = 0,
    localparam int SEL_W     = sel_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          key,
    input  logic                key_sel,
    output logic [CHANNELS-1:0] led,
    output logic [SEL_W-1:0]    sel,
    output logic [PWM_W-1:0]    duty_o,
    output logic [CHANNELS-1:0] breathe
);

    localparam int               c_sel_slots = 2 ** SEL_W;
    localparam int               c_sel_bit   = 2;
    localparam logic [SEL_W-1:0] c_sel_last  = SEL_W'(CHANNELS - 1);

    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic               r_sel_smp;
    logic [PRESC_W-1:0] r_presc;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic [STEP_W-1:0]  r_step;
    logic [SEL_W-1:0]   r_sel;

    logic               w_pwm_tick;
    logic               w_period_end;
    logic               w_step_tick;
    logic               w_up;
    logic               w_dn;
    logic               w_sel_adv;
    step_cmd_t          w_cmd;
    logic [PWM_W-1:0]   w_duty [c_sel_slots];

    assign w_pwm_tick   = &r_presc;
    assign w_period_end = w_pwm_tick & (&r_pwm_cnt);
    assign w_step_tick  = &r_step;
    assign w_up         = r_sync2[KEY_UP];
    assign w_dn         = r_sync2[KEY_DN];
    assign w_sel_adv    = w_step_tick & r_sync2[c_sel_bit] & ~r_sel_smp;

`ifdef PWM_LED_BREATHE_EN
    logic r_both_smp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_both_smp <= 1'b0;
        else if (w_step_tick)
            r_both_smp <= w_up & w_dn;
    end
`endif

    always_comb begin
        w_cmd = HOLD;
        if (w_up && !w_dn)
            w_cmd = INC;
        else if (w_dn && !w_up)
            w_cmd = DEC;
`ifdef PWM_LED_BREATHE_EN
        else if (w_up && w_dn && !r_both_smp)
            w_cmd = TOGGLE;
`endif
    end

    // Keys are only looked at on step_tick, which doubles as the debounce interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sel_smp <= 1'b0;
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_step    <= '0;
            r_sel     <= '0;
        end else begin
            r_sync1 <= {key_sel, key};
            r_sync2 <= r_sync1;
            if (w_step_tick)
                r_sel_smp <= r_sync2[c_sel_bit];
            r_presc <= r_presc + 1'b1;
            if (w_pwm_tick)
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_step <= r_step + 1'b1;
            if (w_sel_adv)
                r_sel <= (r_sel == c_sel_last) ? '0 : r_sel + 1'b1;
        end
    end

    // Unused select codes read back as zero duty.
    generate
        for (genvar i = 0; i < c_sel_slots; i++) begin : g_chan
            if (i < CHANNELS) begin : g_used
                step_cmd_t w_chan_cmd;

                assign w_chan_cmd = (r_sel == SEL_W'(i)) ? w_cmd : HOLD;

                pwm_led_chan #(
                    .PWM_W     (PWM_W),
                    .DUTY_INIT (DUTY_INIT)
                ) u_chan (
                    .clk        (clk),
                    .rst        (rst),
                    .step_tick  (w_step_tick),
                    .cmd        (w_chan_cmd),
                    .period_end (w_period_end),
                    .pwm_cnt    (r_pwm_cnt),
                    .led        (led[i]),
                    .duty       (w_duty[i]),
                    .breathe    (breathe[i])
                );
            end else begin : g_pad
                assign w_duty[i] = '0;
            end
        end
    endgenerate

    assign sel    = r_sel;
    assign duty_o = w_duty[r_sel];

endmodule
`default_nettype wire
